bn_stream: RTL

Parametrised streaming batch-normalisation engine for the BN datapath: C channels of signed N-bit activations, batch size 2^LOG2B, valid/ready handshakes on input and output. A STAT pass accumulates per-channel sum and sum-of-squares and reports batch mean and variance. An APPLY pass re-streams the batch and produces y = ((x − mean)·gamma >>> FRAC) + beta. gamma is the host-computed scale gamma/sqrt(var+eps), loaded from the reported variance.

---
 rtl/bn_stream.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/bn_stream.sv
// bn_stream: streaming batch-norm engine with STAT and APPLY passes.
// Optional running statistics are compiled in with BN_RUNNING_STATS_EN.
module bn_stream #(
    parameter int N      = 16,
    parameter int C      = 4,
    parameter int LOG2B  = 3,
    parameter int FRAC   = 8,
    parameter int MOM_SH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic               infer,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [C*N-1:0]     x_in,
    input  logic [C*N-1:0]     gamma,
    input  logic [C*N-1:0]     beta,
    output logic               stat_done,
    output logic [C*N-1:0]     mean_out,
    output logic [C*2*N-1:0]   var_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [C*2*N-1:0]   y_out
`ifdef BN_RUNNING_STATS_EN
    ,
    output logic [C*N-1:0]     run_mean_out,
    output logic [C*2*N-1:0]   run_var_out
`endif
);

    localparam int B  = 1 << LOG2B;
    localparam int SW = N + LOG2B;
    localparam int QW = 2 * N + LOG2B;
    localparam int CW = LOG2B + 1;

    typedef enum logic [1:0] {IDLE, ACC, FIN, APPLY} state_t;

    state_t state, state_n;

    logic [SW-1:0]  sum   [C];
    logic [QW-1:0]  sumsq [C];
    logic [CW-1:0]  in_cnt, out_cnt;
    logic           in_acc, out_acc;

    logic [N-1:0]   mean_c [C];
    logic [2*N-1:0] var_c  [C];
    logic [2*N-1:0] xsq    [C];
    logic [2*N-1:0] y_c    [C];

`ifdef BN_RUNNING_STATS_EN
    logic           use_run;
    logic [N-1:0]   rm_c [C];
    logic [2*N-1:0] rv_c [C];
`else
    logic unused_cfg;
    assign unused_cfg = infer ^ (MOM_SH > 0);
`endif

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        unique case (state)
            IDLE: if (start) state_n = mode ? APPLY : ACC;
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_cnt == CW'(B - 1)) state_n = FIN;
            end
            FIN: state_n = IDLE;
            APPLY: begin
                in_ready = (!out_valid || out_ready) && (in_cnt < CW'(B));
                if (out_acc && out_cnt == CW'(B - 1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    for (genvar c = 0; c < C; c++) begin : g_ch
        logic signed [N-1:0]   x, g, b, m;
        logic signed [2*N-1:0] xe, me, msq;
        logic signed [2*N:0]   var_w;
        logic signed [N:0]     d;
        logic signed [2*N:0]   p;
        logic signed [2*N+1:0] psh, yw;

        assign x  = x_in[c*N +: N];
        assign g  = gamma[c*N +: N];
        assign b  = beta[c*N +: N];
        assign xe = {{N{x[N-1]}}, x};
        assign xsq[c] = xe * xe;

        // Dropping the low LOG2B bits is the floor division by B.
        assign mean_c[c] = sum[c][SW-1:LOG2B];
        assign me    = {{N{mean_c[c][N-1]}}, mean_c[c]};
        assign msq   = me * me;
        assign var_w = {1'b0, sumsq[c][QW-1:LOG2B]} - {1'b0, msq};
        assign var_c[c] = var_w[2*N] ? '0 : var_w[2*N-1:0];

`ifdef BN_RUNNING_STATS_EN
        logic [N-1:0]          rm, rv_unused_hi;
        logic [2*N-1:0]        rv;
        logic signed [N:0]     rm_d, rm_sh, rm_n;
        logic signed [2*N:0]   rv_d, rv_sh, rv_n;

        assign rm    = run_mean_out[c*N +: N];
        assign rv    = run_var_out[c*2*N +: 2*N];
        assign rm_d  = {mean_c[c][N-1], mean_c[c]} - {rm[N-1], rm};
        assign rm_sh = rm_d >>> MOM_SH;
        assign rm_n  = {rm[N-1], rm} + rm_sh;
        assign rm_c[c] = (rm_n[N] != rm_n[N-1])
                       ? {rm_n[N], {(N-1){~rm_n[N]}}}
                       : rm_n[N-1:0];
        assign rv_d  = {1'b0, var_c[c]} - {1'b0, rv};
        assign rv_sh = rv_d >>> MOM_SH;
        assign rv_n  = {1'b0, rv} + rv_sh;
        assign rv_c[c] = rv_n[2*N] ? '0 : rv_n[2*N-1:0];
        assign rv_unused_hi = '0;
        assign m = use_run ? rm : mean_out[c*N +: N];
`else
        assign m = mean_out[c*N +: N];
`endif

        assign d   = {x[N-1], x} - {m[N-1], m};
        assign p   = $signed({{N{d[N]}}, d}) * $signed({{(N+1){g[N-1]}}, g});
        assign psh = $signed({p[2*N], p}) >>> FRAC;
        assign yw  = psh + $signed({{(N+2){b[N-1]}}, b});

        // Saturate to signed 2N when the top three bits disagree.
        assign y_c[c] = (yw[2*N+1:2*N-1] == 3'b000 || yw[2*N+1:2*N-1] == 3'b111)
                      ? yw[2*N-1:0]
                      : (yw[2*N+1] ? {1'b1, {(2*N-1){1'b0}}}
                                   : {1'b0, {(2*N-1){1'b1}}});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            stat_done <= 1'b0;
            out_valid <= 1'b0;
            mean_out  <= '0;
            var_out   <= '0;
            y_out     <= '0;
            for (int c = 0; c < C; c++) begin
                sum[c]   <= '0;
                sumsq[c] <= '0;
            end
`ifdef BN_RUNNING_STATS_EN
            use_run      <= 1'b0;
            run_mean_out <= '0;
            run_var_out  <= '0;
`endif
        end else begin
            state     <= state_n;
            stat_done <= (state == FIN);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        in_cnt  <= '0;
                        out_cnt <= '0;
`ifdef BN_RUNNING_STATS_EN
                        use_run <= infer;
`endif
                        if (!mode) begin
                            for (int c = 0; c < C; c++) begin
                                sum[c]   <= '0;
                                sumsq[c] <= '0;
                            end
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        in_cnt <= in_cnt + CW'(1);
                        for (int c = 0; c < C; c++) begin
                            sum[c] <= sum[c] + {{LOG2B{x_in[c*N+N-1]}}, x_in[c*N +: N]};
                            sumsq[c] <= sumsq[c] + {{LOG2B{1'b0}}, xsq[c]};
                        end
                    end
                end
                FIN: begin
                    for (int c = 0; c < C; c++) begin
                        mean_out[c*N +: N]    <= mean_c[c];
                        var_out[c*2*N +: 2*N] <= var_c[c];
`ifdef BN_RUNNING_STATS_EN
                        run_mean_out[c*N +: N]    <= rm_c[c];
                        run_var_out[c*2*N +: 2*N] <= rv_c[c];
`endif
                    end
                end
                APPLY: begin
                    if (in_acc) begin
                        in_cnt    <= in_cnt + CW'(1);
                        out_valid <= 1'b1;
                        for (int c = 0; c < C; c++)
                            y_out[c*2*N +: 2*N] <= y_c[c];
                    end else if (out_acc) begin
                        out_valid <= 1'b0;
                    end
                    if (out_acc) out_cnt <= out_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
